// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared types and constants for the ALU op sequencer
package alu_seq_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int IDX_W_DEF    = 4;
    localparam int OP_W_DEF     = 5;

    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd15;
    localparam logic [4:0] OP_DIV = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MDR_LOAD = 3'd1,
        S_REG_LOAD = 3'd2,
        S_Y_LOAD   = 3'd3,
        S_ALU_OP   = 3'd4,
        S_WB_LO    = 3'd5,
        S_WB_HI    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command inputs and data_path strobes of the sequencer
interface alu_op_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int OP_W     = OP_W_DEF
);
    logic                start;
    logic                load_mode;
    logic [OP_W-1:0]     op_in;
    logic [IDX_W-1:0]    rd;
    logic [IDX_W-1:0]    rs;
    logic [IDX_W-1:0]    rt;

    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic                Yin;
    logic                Zlowin;
    logic                ZHighin;
    logic                Zlowout;
    logic                Zhighout;
    logic                HIin;
    logic                LOin;
    logic                MDRin;
    logic                MDRout;
    logic                Read;
    logic [OP_W-1:0]     op;
    logic                busy;
    logic                done;

    modport master (
        output start, load_mode, op_in, rd, rs, rt,
        input  Rout, Rin, Yin, Zlowin, ZHighin, Zlowout, Zhighout,
               HIin, LOin, MDRin, MDRout, Read, op, busy, done
    );

    modport slave (
        input  start, load_mode, op_in, rd, rs, rt,
        output Rout, Rin, Yin, Zlowin, ZHighin, Zlowout, Zhighout,
               HIin, LOin, MDRin, MDRout, Read, op, busy, done
    );

endinterface

// File: rtl/alu_op_sequencer_onehot_decode.sv
// rtl/alu_op_sequencer_onehot_decode.sv - register index to one-hot enable decoder
module onehot_decode #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Indices at or beyond NUM_REGS match no bit, so the output stays all-zero.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_en && (int'(i_idx) == i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - Moore control sequencer producing data_path strobes
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int              NUM_REGS = NUM_REGS_DEF,
    parameter int              IDX_W    = IDX_W_DEF,
    parameter int              OP_W     = OP_W_DEF,
    parameter logic [OP_W-1:0] MUL_OP   = OP_W'(OP_MUL),
    parameter logic [OP_W-1:0] DIV_OP   = OP_W'(OP_DIV)
) (
    input  logic Clock,
    input  logic clear,
    alu_op_sequencer_if.slave io_bus
);

    state_t              r_state;
    state_t              w_next;

    logic [OP_W-1:0]     r_op;
    logic [IDX_W-1:0]    r_rd;
    logic [IDX_W-1:0]    r_rt;
    logic                r_wide;
    logic                w_wide;

    logic                r_rin_en;
    logic [IDX_W-1:0]    r_rin_idx;
    logic                r_rout_en;
    logic [IDX_W-1:0]    r_rout_idx;

    logic                r_yin;
    logic                r_zlowin;
    logic                r_zhighin;
    logic                r_zlowout;
    logic                r_zhighout;
    logic                r_hiin;
    logic                r_loin;
    logic                r_mdrin;
    logic                r_mdrout;
    logic                r_read;
    logic [OP_W-1:0]     r_op_out;
    logic                r_busy;
    logic                r_done;

    logic [NUM_REGS-1:0] w_rin;
    logic [NUM_REGS-1:0] w_rout;

    assign w_wide = (io_bus.op_in == MUL_OP) || (io_bus.op_in == DIV_OP);

    // Next-state selection; start is only looked at in IDLE, so commands never queue.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (io_bus.start) w_next = io_bus.load_mode ? S_MDR_LOAD : S_Y_LOAD;
            S_MDR_LOAD: w_next = S_REG_LOAD;
            S_REG_LOAD: w_next = S_DONE;
            S_Y_LOAD:   w_next = S_ALU_OP;
            S_ALU_OP:   w_next = S_WB_LO;
            S_WB_LO:    w_next = r_wide ? S_WB_HI : S_DONE;
            S_WB_HI:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // State register, command latch, and outputs registered from the state being entered.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_rt       <= '0;
            r_wide     <= 1'b0;
            r_rin_en   <= 1'b0;
            r_rin_idx  <= '0;
            r_rout_en  <= 1'b0;
            r_rout_idx <= '0;
            r_yin      <= 1'b0;
            r_zlowin   <= 1'b0;
            r_zhighin  <= 1'b0;
            r_zlowout  <= 1'b0;
            r_zhighout <= 1'b0;
            r_hiin     <= 1'b0;
            r_loin     <= 1'b0;
            r_mdrin    <= 1'b0;
            r_mdrout   <= 1'b0;
            r_read     <= 1'b0;
            r_op_out   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && io_bus.start) begin
                r_op   <= io_bus.op_in;
                r_rd   <= io_bus.rd;
                r_rt   <= io_bus.rt;
                r_wide <= w_wide;
            end

            r_rin_en   <= 1'b0;
            r_rin_idx  <= '0;
            r_rout_en  <= 1'b0;
            r_rout_idx <= '0;
            r_yin      <= 1'b0;
            r_zlowin   <= 1'b0;
            r_zhighin  <= 1'b0;
            r_zlowout  <= 1'b0;
            r_zhighout <= 1'b0;
            r_hiin     <= 1'b0;
            r_loin     <= 1'b0;
            r_mdrin    <= 1'b0;
            r_mdrout   <= 1'b0;
            r_read     <= 1'b0;
            r_op_out   <= '0;
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);

            case (w_next)
                S_MDR_LOAD: begin
                    r_read  <= 1'b1;
                    r_mdrin <= 1'b1;
                end
                S_REG_LOAD: begin
                    r_mdrout  <= 1'b1;
                    r_rin_en  <= 1'b1;
                    r_rin_idx <= r_rd;
                end
                S_Y_LOAD: begin
                    // Only entered from IDLE, where rs is still on the command inputs.
                    r_rout_en  <= 1'b1;
                    r_rout_idx <= io_bus.rs;
                    r_yin      <= 1'b1;
                end
                S_ALU_OP: begin
                    r_rout_en  <= 1'b1;
                    r_rout_idx <= r_rt;
                    r_op_out   <= r_op;
                    r_zlowin   <= 1'b1;
                    r_zhighin  <= r_wide;
                end
                S_WB_LO: begin
                    r_zlowout <= 1'b1;
                    r_loin    <= r_wide;
                    r_rin_en  <= ~r_wide;
                    r_rin_idx <= r_rd;
                end
                S_WB_HI: begin
                    r_zhighout <= 1'b1;
                    r_hiin     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rin_dec (
        .i_idx    (r_rin_idx),
        .i_en     (r_rin_en),
        .o_onehot (w_rin)
    );

    onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rout_dec (
        .i_idx    (r_rout_idx),
        .i_en     (r_rout_en),
        .o_onehot (w_rout)
    );

    assign io_bus.Rin      = w_rin;
    assign io_bus.Rout     = w_rout;
    assign io_bus.Yin      = r_yin;
    assign io_bus.Zlowin   = r_zlowin;
    assign io_bus.ZHighin  = r_zhighin;
    assign io_bus.Zlowout  = r_zlowout;
    assign io_bus.Zhighout = r_zhighout;
    assign io_bus.HIin     = r_hiin;
    assign io_bus.LOin     = r_loin;
    assign io_bus.MDRin    = r_mdrin;
    assign io_bus.MDRout   = r_mdrout;
    assign io_bus.Read     = r_read;
    assign io_bus.op       = r_op_out;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int NR = 16;
    localparam int IW = 5;
    localparam int OW = 5;

    localparam logic [9:0] ST_READ     = 10'h200;
    localparam logic [9:0] ST_MDRIN    = 10'h100;
    localparam logic [9:0] ST_MDROUT   = 10'h080;
    localparam logic [9:0] ST_YIN      = 10'h040;
    localparam logic [9:0] ST_ZLOWIN   = 10'h020;
    localparam logic [9:0] ST_ZHIGHIN  = 10'h010;
    localparam logic [9:0] ST_ZLOWOUT  = 10'h008;
    localparam logic [9:0] ST_ZHIGHOUT = 10'h004;
    localparam logic [9:0] ST_LOIN     = 10'h002;
    localparam logic [9:0] ST_HIIN     = 10'h001;

    typedef struct packed {
        logic [NR-1:0] rin;
        logic [NR-1:0] rout;
        logic [9:0]    stb;
        logic [OW-1:0] op;
        logic          busy;
        logic          done;
    } vec_t;

    logic clk;
    logic clear;
    int   vectors;
    int   miscompares;
    vec_t exp_q[$];
    vec_t obs;

    alu_op_sequencer_if #(.NUM_REGS(NR), .IDX_W(IW), .OP_W(OW)) bus ();

    alu_op_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .OP_W(OW)) dut (
        .Clock  (clk),
        .clear  (clear),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NR-1:0] oh(input int idx);
        if (idx < NR) return NR'(1) << idx;
        return '0;
    endfunction

    // Expected per-cycle outputs of one command, from the cycle after start is sampled to done.
    function automatic void model_cmd(input bit lm, input int op, input int rd, input int rs, input int rt);
        vec_t e;
        bit   wide;
        wide = (op == 15) || (op == 16);
        exp_q.delete();
        if (lm) begin
            e = '0; e.busy = 1'b1; e.stb = ST_READ | ST_MDRIN;            exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.stb = ST_MDROUT; e.rin = oh(rd);     exp_q.push_back(e);
        end else begin
            e = '0; e.busy = 1'b1; e.stb = ST_YIN; e.rout = oh(rs);       exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.rout = oh(rt); e.op = OW'(op);
            e.stb = ST_ZLOWIN | (wide ? ST_ZHIGHIN : 10'h0);              exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.stb = ST_ZLOWOUT;
            if (wide) e.stb = e.stb | ST_LOIN; else e.rin = oh(rd);
            exp_q.push_back(e);
            if (wide) begin
                e = '0; e.busy = 1'b1; e.stb = ST_ZHIGHOUT | ST_HIIN;     exp_q.push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;                             exp_q.push_back(e);
    endfunction

    function automatic vec_t get_obs();
        vec_t o;
        o.rin  = bus.Rin;
        o.rout = bus.Rout;
        o.stb  = {bus.Read, bus.MDRin, bus.MDRout, bus.Yin, bus.Zlowin, bus.ZHighin,
                  bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin};
        o.op   = bus.op;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("rin=%h rout=%h stb=%b op=%0d busy=%b done=%b", v.rin, v.rout, v.stb, v.op, v.busy, v.done);
    endfunction

    // Call at a negedge; start is then sampled at the following posedge.
    task automatic issue(input bit lm, input int op, input int rd, input int rs, input int rt);
        bus.start     = 1'b1;
        bus.load_mode = lm;
        bus.op_in     = OW'(op);
        bus.rd        = IW'(rd);
        bus.rs        = IW'(rs);
        bus.rt        = IW'(rt);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = get_obs();
        vectors++;
        if (obs !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL reset_state got %s expected all zero", fmt(obs));
        end
        clear = 1'b0;
        @(negedge clk);
        obs = get_obs();
        vectors++;
        if (obs !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL idle_after_reset got %s expected all zero", fmt(obs));
        end
    endtask

    task automatic test_cmd(input string name, input bit lm, input int op, input int rd, input int rs, input int rt);
        issue(lm, op, rd, rs, rt);
        model_cmd(lm, op, rd, rs, rt);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            obs = get_obs();
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s cycle N+%0d got %s expected %s", name, k + 1, fmt(obs), fmt(exp_q[k]));
            end
        end
        @(negedge clk);
        obs = get_obs();
        vectors++;
        if (obs !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL %s idle_after_done got %s expected all zero", name, fmt(obs));
        end
    endtask

    task automatic test_preload();
        test_cmd("preload_r3", 1'b1, 0, 3, 0, 0);
    endtask

    task automatic test_and();
        test_cmd("preload_r2", 1'b1, 0, 2, 0, 0);
        test_cmd("and_r1", 1'b0, 1, 1, 3, 2);
    endtask

    task automatic test_wide();
        test_cmd("mul_wide", 1'b0, 15, 4, 3, 2);
        test_cmd("div_wide", 1'b0, 16, 6, 2, 3);
        test_cmd("not_wide_14", 1'b0, 14, 7, 3, 3);
    endtask

    task automatic test_out_of_range();
        test_cmd("oor_preload_rd20", 1'b1, 0, 20, 0, 0);
        test_cmd("oor_alu", 1'b0, 2, 20, 17, 31);
        test_cmd("boundary_r15", 1'b0, 3, 15, 15, 16);
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 15, 1, 3, 2);
        model_cmd(1'b0, 15, 1, 3, 2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            obs = get_obs();
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL reset_mid cycle N+%0d got %s expected %s", k + 1, fmt(obs), fmt(exp_q[k]));
            end
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = get_obs();
            vectors++;
            if (obs !== vec_t'('0)) begin
                miscompares++;
                $display("FAIL reset_mid_abandon cycle %0d got %s expected all zero", k, fmt(obs));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 16, 5, 6, 7);
        model_cmd(1'b0, 16, 5, 6, 7);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            obs = get_obs();
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL b2b_first cycle N+%0d got %s expected %s", k + 1, fmt(obs), fmt(exp_q[k]));
            end
            if (k < exp_q.size() - 1) begin
                bus.load_mode = 1'($urandom_range(0, 1));
                bus.op_in     = OW'($urandom_range(0, 31));
                bus.rd        = IW'($urandom_range(0, 31));
                bus.rs        = IW'($urandom_range(0, 31));
                bus.rt        = IW'($urandom_range(0, 31));
            end else begin
                issue(1'b1, 0, 9, 0, 0);
            end
        end
        @(negedge clk);
        obs = get_obs();
        vectors++;
        if (obs !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL b2b_idle_gap got %s expected all zero", fmt(obs));
        end
        model_cmd(1'b1, 0, 9, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
            obs = get_obs();
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL b2b_second cycle N+%0d got %s expected %s", k + 1, fmt(obs), fmt(exp_q[k]));
            end
        end
        @(negedge clk);
        obs = get_obs();
        vectors++;
        if (obs !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL b2b_final_idle got %s expected all zero", fmt(obs));
        end
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       op = 15;
                1:       op = 16;
                default: op = int'($urandom_range(0, 31));
            endcase
            test_cmd($sformatf("random_%0d", n), 1'($urandom_range(0, 1)), op,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.load_mode = 1'b0;
        bus.op_in     = '0;
        bus.rd        = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        @(negedge clk);
        test_reset();
        test_preload();
        test_and();
        test_wide();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
